// File: rtl/prog_feeder_if.sv
// Bundles the program-load port, the run control and the core handshake of prog_feeder.
interface prog_feeder_if #(
    parameter int REG_WIDTH   = 16,
    parameter int ADDR_WIDTH  = 4,
    parameter int COUNT_WIDTH = 8
);
    logic                   ld_en;
    logic [ADDR_WIDTH-1:0]  ld_addr;
    logic [REG_WIDTH-1:0]   ld_data;
    logic                   start;
    logic [ADDR_WIDTH:0]    len;
    logic                   done;
    logic                   run;
    logic [REG_WIDTH-1:0]   din;
    logic                   busy;
    logic                   finished;
    logic                   timeout_err;
    logic [ADDR_WIDTH:0]    pc;
    logic [COUNT_WIDTH-1:0] instr_count;

    modport master (
        input  ld_en, ld_addr, ld_data, start, len, done,
        output run, din, busy, finished, timeout_err, pc, instr_count
    );

    modport slave (
        output ld_en, ld_addr, ld_data, start, len, done,
        input  run, din, busy, finished, timeout_err, pc, instr_count
    );
endinterface

// File: rtl/prog_feeder.sv
// Program sequencer feeding a processor core: issues each stored word with a run pulse,
// supplies the mvi immediate while waiting for done, and aborts through a watchdog.
module prog_feeder #(
    parameter int REG_WIDTH         = 16,
    parameter int INSTRUCTION_WIDTH = 9,
    parameter int ADDR_WIDTH        = 4,
    parameter int COUNT_WIDTH       = 8,
    parameter int TIMEOUT           = 16
) (
    input  logic          clk,
    input  logic          rst,
    prog_feeder_if.master bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, FINISH} state_t;

    state_t                 state, state_next;
    logic [REG_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH:0]    pc, len_q, pc_step;
    logic [ADDR_WIDTH-1:0]  pc_idx, imm_idx;
    logic [COUNT_WIDTH-1:0] instr_count;
    logic [WD_W-1:0]        wdog;
    logic                   mvi_q, timeout_err, wdog_expire;
    logic [REG_WIDTH-1:0]   cur_word, din_word;
    logic [2:0]             opcode;
    logic                   issue_pulse, busy_flag, finish_pulse;

    assign pc_idx      = pc[ADDR_WIDTH-1:0];
    assign imm_idx     = pc_idx + ADDR_WIDTH'(1);
    assign cur_word    = mem[pc_idx];
    assign opcode      = cur_word[INSTRUCTION_WIDTH-1 -: 3];
    // pc never exceeds DEPTH-1 while issuing, so the extra bit absorbs +2 without wrapping
    assign pc_step     = pc + (mvi_q ? (ADDR_WIDTH+1)'(2) : (ADDR_WIDTH+1)'(1));
    assign wdog_expire = (wdog == WD_LAST);

    // Program memory is deliberately left out of reset so a program survives it.
    always_ff @(posedge clk) begin
        if (bus.ld_en && state == IDLE)
            mem[bus.ld_addr] <= bus.ld_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        issue_pulse  = 1'b0;
        busy_flag    = 1'b0;
        finish_pulse = 1'b0;
        din_word     = '0;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_next = (bus.len != '0) ? ISSUE : FINISH;
            end
            ISSUE: begin
                issue_pulse = 1'b1;
                busy_flag   = 1'b1;
                din_word    = cur_word;
                state_next  = WAIT_DONE;
            end
            WAIT_DONE: begin
                busy_flag = 1'b1;
                din_word  = mvi_q ? mem[imm_idx] : cur_word;
                // done takes priority over a watchdog expiring on the same edge
                if (bus.done)
                    state_next = (pc_step >= len_q) ? FINISH : ISSUE;
                else if (wdog_expire)
                    state_next = IDLE;
            end
            FINISH: begin
                finish_pulse = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= '0;
            len_q       <= '0;
            instr_count <= '0;
            wdog        <= '0;
            mvi_q       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        timeout_err <= 1'b0;
                        if (bus.len != '0) begin
                            len_q       <= bus.len;
                            pc          <= '0;
                            instr_count <= '0;
                        end
                    end
                end
                ISSUE: begin
                    mvi_q <= (opcode == 3'b001);
                    wdog  <= '0;
                end
                WAIT_DONE: begin
                    if (bus.done) begin
                        pc          <= pc_step;
                        instr_count <= instr_count + COUNT_WIDTH'(1);
                    end else if (wdog_expire) begin
                        timeout_err <= 1'b1;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.run         = issue_pulse;
    assign bus.din         = din_word;
    assign bus.busy        = busy_flag;
    assign bus.finished    = finish_pulse;
    assign bus.timeout_err = timeout_err;
    assign bus.pc          = pc;
    assign bus.instr_count = instr_count;
endmodule

// File: tb/tb_prog_feeder.sv
// Directed bench for prog_feeder with a small core stub that executes mv/mvi/add.
module tb_prog_feeder;
    localparam int RW = 16;
    localparam int AW = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_feeder_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

    prog_feeder #(
        .REG_WIDTH(RW), .INSTRUCTION_WIDTH(9), .ADDR_WIDTH(AW),
        .COUNT_WIDTH(CW), .TIMEOUT(16)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Core stub: raises done dly cycles after run, executing the issued word at that point.
    int          dly     = 2;
    bit          stub_en = 1'b1;
    int          cnt     = 0;
    int          n_iss   = 0;
    int          fin_cnt = 0;
    logic        done_s  = 1'b0;
    logic [15:0] cur;
    logic [15:0] regs    [8];
    logic [15:0] issued  [64];
    logic [15:0] imm_log [64];
    logic [4:0]  pc_log  [64];

    assign bus.done = done_s;

    always @(negedge clk) begin
        if (rst) begin
            cnt    = 0;
            done_s = 1'b0;
            for (int i = 0; i < 8; i++) regs[i] = '0;
        end else begin
            done_s = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    done_s = 1'b1;
                    case (cur[8:6])
                        3'b000: regs[cur[5:3]] = regs[cur[2:0]];
                        3'b001: begin
                            regs[cur[5:3]]    = bus.din;
                            imm_log[n_iss-1] = bus.din;
                        end
                        3'b010: regs[cur[5:3]] = regs[cur[5:3]] + regs[cur[2:0]];
                        default: ;
                    endcase
                end
            end
            if (bus.run === 1'b1 && n_iss < 63) begin
                cur            = bus.din;
                issued[n_iss]  = bus.din;
                pc_log[n_iss]  = bus.pc;
                n_iss++;
                if (stub_en) cnt = dly;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.finished === 1'b1) fin_cnt++;
    end

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        bus.ld_en   = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        @(negedge clk);
        bus.ld_en = 1'b0;
    endtask

    task automatic go(input logic [4:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (bus.busy === 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_completes"}, 32'(k < budget), 32'd1);
        @(negedge clk);
    endtask

    task automatic load_prog();
        load(4'd0, 16'h0040);
        load(4'd1, 16'h0005);
        load(4'd2, 16'h0048);
        load(4'd3, 16'h0003);
        load(4'd4, 16'h0081);
    endtask

    int b, f0;

    initial begin
        bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        bus.start = 1'b0; bus.len = '0;
        #1;
        check("rst_run",   bus.run, 0);
        check("rst_din",   bus.din, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_fin",   bus.finished, 0);
        check("rst_terr",  bus.timeout_err, 0);
        check("rst_pc",    bus.pc, 0);
        check("rst_icnt",  bus.instr_count, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Zero-length program
        f0 = fin_cnt; b = n_iss;
        go(5'd0);
        check("len0_fin",  bus.finished, 1);
        check("len0_busy", bus.busy, 0);
        check("len0_run",  bus.run, 0);
        @(negedge clk);
        check("len0_fin_lo",  bus.finished, 0);
        check("len0_icnt",    bus.instr_count, 0);
        check("len0_fincnt",  fin_cnt - f0, 1);
        check("len0_noissue", n_iss - b, 0);

        // mvi R0,#5 ; mvi R1,#3 ; add R0,R1
        load_prog();
        dly = 2; b = n_iss; f0 = fin_cnt;
        go(5'd5);
        wait_idle(100, "prog");
        check("prog_nissue", n_iss - b, 3);
        check("prog_i0",     issued[b],   16'h0040);
        check("prog_i1",     issued[b+1], 16'h0048);
        check("prog_i2",     issued[b+2], 16'h0081);
        check("prog_imm0",   imm_log[b],   16'h0005);
        check("prog_imm1",   imm_log[b+1], 16'h0003);
        check("prog_r0",     regs[0], 16'd8);
        check("prog_fin",    fin_cnt - f0, 1);
        check("prog_icnt",   bus.instr_count, 3);
        check("prog_pc",     bus.pc, 5);
        check("prog_terr",   bus.timeout_err, 0);

        // mv R1,R0 ; mv R2,R1 with a slower core
        load(4'd0, 16'h0008);
        load(4'd1, 16'h0011);
        dly = 3; b = n_iss; f0 = fin_cnt;
        go(5'd2);
        wait_idle(100, "mv");
        check("mv_nissue", n_iss - b, 2);
        check("mv_pc0",    pc_log[b],   0);
        check("mv_pc1",    pc_log[b+1], 1);
        check("mv_pc",     bus.pc, 2);
        check("mv_icnt",   bus.instr_count, 2);
        check("mv_r2",     regs[2], 16'd8);
        check("mv_fin",    fin_cnt - f0, 1);

        // Core never answers: watchdog abort after 16 WAIT_DONE cycles
        stub_en = 1'b0; f0 = fin_cnt;
        go(5'd2);
        repeat (15) @(negedge clk);
        @(negedge clk);
        check("wd_terr_pre", bus.timeout_err, 0);
        check("wd_busy_pre", bus.busy, 1);
        @(negedge clk);
        check("wd_terr",  bus.timeout_err, 1);
        check("wd_busy",  bus.busy, 0);
        check("wd_fin",   bus.finished, 0);
        @(negedge clk);
        check("wd_fincnt", fin_cnt - f0, 0);
        check("wd_pc",     bus.pc, 0);
        check("wd_icnt",   bus.instr_count, 0);
        check("wd_sticky", bus.timeout_err, 1);
        stub_en = 1'b1;
        go(5'd2);
        check("wd_clear", bus.timeout_err, 0);
        wait_idle(100, "wd_rerun");
        check("wd_rerun_icnt", bus.instr_count, 2);

        // Loads and start while busy are ignored
        load_prog();
        dly = 4; b = n_iss; f0 = fin_cnt;
        go(5'd5);
        @(negedge clk);
        bus.ld_en = 1'b1; bus.ld_addr = 4'd3; bus.ld_data = 16'hFFFF;
        bus.start = 1'b1; bus.len = 5'd1;
        @(negedge clk);
        bus.ld_en = 1'b0; bus.start = 1'b0;
        wait_idle(200, "busy_ld");
        check("busy_nissue", n_iss - b, 3);
        check("busy_imm1",   imm_log[b+1], 16'h0003);
        check("busy_icnt",   bus.instr_count, 3);
        check("busy_pc",     bus.pc, 5);
        check("busy_fin",    fin_cnt - f0, 1);

        // Reset in the middle of the second instruction's WAIT_DONE
        dly = 6;
        go(5'd5);
        repeat (8) @(negedge clk);
        check("mid_pc_pre",   bus.pc, 2);
        check("mid_busy_pre", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_run",  bus.run, 0);
        check("mid_din",  bus.din, 0);
        check("mid_busy", bus.busy, 0);
        check("mid_pc",   bus.pc, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dly = 2; b = n_iss; f0 = fin_cnt;
        go(5'd5);
        wait_idle(100, "rerun");
        check("rerun_i0",   issued[b], 16'h0040);
        check("rerun_imm1", imm_log[b+1], 16'h0003);
        check("rerun_r0",   regs[0], 16'd8);
        check("rerun_icnt", bus.instr_count, 3);
        check("rerun_fin",  fin_cnt - f0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: bench did not reach its end");
        $fatal(1);
    end
endmodule

// File: doc/prog_feeder.md
Name: prog_feeder

Overview:
- Program sequencer that sits directly upstream of the processor core. It drives the core's din and run inputs and consumes its done output.
- It holds a small loadable program memory of 16-bit words. It issues each instruction with a one-cycle run pulse and supplies the following word as the immediate for mvi.
- It waits for done before issuing the next instruction, and stops after a programmed length.
- A watchdog aborts the run if the core never returns done.

Parameters:
REG_WIDTH, 16, width of din and of each memory word
INSTRUCTION_WIDTH, 9, instruction field in the low bits of a word; opcode is bits [INSTRUCTION_WIDTH-1 -: 3]
ADDR_WIDTH, 4, program address width; DEPTH = 2**ADDR_WIDTH words
COUNT_WIDTH, 8, width of the executed-instruction counter
TIMEOUT, 16, maximum cycles spent in WAIT_DONE before abort (must be >= 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
ld_en  in  1  program-memory write strobe
ld_addr  in  ADDR_WIDTH  write address
ld_data  in  REG_WIDTH  write data
start  in  1  begin execution from address 0
len  in  ADDR_WIDTH+1  number of memory words in the program (0..DEPTH)
done  in  1  instruction complete, from the core
run  out  1  one-cycle issue pulse to the core
din  out  REG_WIDTH  instruction or immediate word to the core
busy  out  1  high from accepted start until finish or abort
finished  out  1  one-cycle pulse at normal completion
timeout_err  out  1  sticky abort flag
pc  out  ADDR_WIDTH+1  current program address
instr_count  out  COUNT_WIDTH  instructions completed in this run

Behaviour:
- Reset is asynchronous and active-high; a single clock is used. Reset values:
  - state = IDLE
  - pc = 0, instr_count = 0
  - run = 0, din = 0
  - busy = 0, finished = 0, timeout_err = 0
  - internal mvi flag (mvi_q) and watchdog = 0
- Program memory is not cleared by reset.
- Memory writes:
  - A write occurs on the rising edge when ld_en=1 and state=IDLE.
  - ld_en in any other state is ignored and the memory is unchanged.
- States: IDLE, ISSUE, WAIT_DONE, FINISH.
- IDLE:
  - din = 0, run = 0, busy = 0.
  - start=1 with len != 0: on the next edge capture len_q = len, set pc = 0, instr_count = 0, timeout_err = 0, then go to ISSUE.
  - start=1 with len = 0: clear timeout_err, then go to FINISH; run is never asserted.
  - If ld_en and start are both high, both take effect: the write lands and the run starts.
- ISSUE (exactly 1 cycle):
  - run = 1, din = mem[pc[ADDR_WIDTH-1:0]].
  - mvi_q is set to (opcode == 3'b001).
  - Next state is WAIT_DONE; the watchdog is cleared.
- WAIT_DONE:
  - run = 0.
  - din = mvi_q ? mem[(pc+1) mod DEPTH] : mem[pc]. din holds stable for the whole state, covering the core's immediate fetch.
  - The watchdog increments each cycle.
  - done=1 sampled on an edge:
    - pc_next = pc + (mvi_q ? 2 : 1), computed in ADDR_WIDTH+1 bits with no wrap.
    - instr_count increments and wraps at 2**COUNT_WIDTH.
    - If pc_next >= len_q go to FINISH, otherwise go to ISSUE.
  - Watchdog reaches TIMEOUT with done=0: set timeout_err=1, go to IDLE, leave pc and instr_count frozen. finished is not pulsed.
  - done and timeout on the same edge: done wins.
- FINISH (1 cycle): finished = 1, busy = 0, din = 0, then go to IDLE.
- busy = 1 in ISSUE and WAIT_DONE.
- start is ignored outside IDLE.
- done while in IDLE, ISSUE or FINISH is ignored.
- An mvi at the last word (pc = len_q-1) takes its immediate from mem[len_q mod DEPTH]. This is legal, and the run then finishes.
- Reset mid-run: all outputs return to their reset values asynchronously. The core shares rst.
- Minimum instruction period is 2 cycles: ISSUE plus at least one WAIT_DONE cycle.

Test Plan:
- Load mem[0..4] = 0x0040, 0x0005, 0x0048, 0x0003, 0x0081 (mvi R0,#5; mvi R1,#3; add R0,R1) and set len = 5.
  - start -> run pulses with din = 0x0040, then 0x0048, then 0x0081.
  - During each WAIT_DONE after an mvi, din = 0x0005 and 0x0003 respectively.
  - Core R0 = 8, finished pulses once, instr_count = 3, pc = 5.
- mv-only program, len = 2: mem = 0x0008, 0x0011 -> exactly two run pulses, each followed by pc += 1; the done stub returns done 3 cycles after run.
- start with len = 0 -> finished pulses on the following cycle; run stays 0, busy stays 0, instr_count = 0.
- Done stub never responds, TIMEOUT = 16 -> timeout_err = 1 exactly 16 cycles after entering WAIT_DONE.
  - busy falls, finished stays 0, pc stays 0.
  - A new start clears timeout_err.
- While busy: ld_en to address 3 with 0xFFFF, plus an extra start pulse -> mem[3] is unchanged and execution continues undisturbed.
- rst asserted mid-WAIT_DONE -> run = 0, din = 0, busy = 0, pc = 0 asynchronously. After release, a start re-runs the program from address 0 using the retained memory.
